// File: rtl/fetch_stage.sv
// Instruction fetch stage: producer side of the IF/ID pipeline latch.
// Owns the PC, issues imem reads, holds a fetched word across decode
// stalls and applies halt / branch redirects from downstream stages.
// Optional build macro FETCH_COUNT_EN adds a delivered-instruction counter
// (fetch_count, width CNT_W).
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
`ifdef FETCH_COUNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] imemload_in,
  output logic [31:0] npc_in,
  output logic        ifid_enable,
  output logic        flush
`ifdef FETCH_COUNT_EN
  , output logic [CNT_W-1:0] fetch_count
`endif
);

  typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] hold_reg, hold_nx;
  logic        ren_raw, en_raw, flush_raw;

  // Redirect targets are word aligned; the low bits carry no information.
  logic unused_redirect_bits;
  assign unused_redirect_bits = &redirect_pc[1:0];

  // State, PC and held-word registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      pc       <= PC_INIT;
      hold_reg <= 32'h0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      hold_reg <= hold_nx;
    end
  end

  // Next-state and strobe logic: halt beats redirect beats normal flow.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    hold_nx     = hold_reg;
    ren_raw     = (state == RUN);
    en_raw      = 1'b0;
    flush_raw   = 1'b0;
    imemload_in = (state == HOLD) ? hold_reg : imemload;
    npc_in      = pc + 32'd4;
    if (state != HALTED) begin
      if (halt) begin
        // Any word returned this cycle is dropped; decode gets a bubble.
        state_nx  = HALTED;
        flush_raw = 1'b1;
      end else if (redirect_valid) begin
        // Applies regardless of stall; wrong-path word (fresh or held) is lost.
        state_nx  = RUN;
        pc_nx     = {redirect_pc[31:2], 2'b00};
        flush_raw = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (ihit && !stall) begin
              en_raw = 1'b1;
              pc_nx  = pc + 32'd4;
            end else if (ihit && stall) begin
              hold_nx  = imemload;
              state_nx = HOLD;
            end else if (!ihit && !stall) begin
              flush_raw = 1'b1;
            end
          end
          HOLD: begin
            if (!stall) begin
              en_raw   = 1'b1;
              pc_nx    = pc + 32'd4;
              state_nx = RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Strobes are forced low while reset is held so nothing leaks out.
  assign iREN        = nRST & ren_raw;
  assign ifid_enable = nRST & en_raw;
  assign flush       = nRST & flush_raw;
  assign imemaddr    = pc;

`ifdef FETCH_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Count every instruction handed to decode; wraps naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt <= '0;
    else if (ifid_enable) cnt <= cnt + 1'b1;
  end

  assign fetch_count = cnt;
`endif

endmodule
